// File: rtl/alu_operand_stage.sv
// ID->EX operand stage: forwarding mux, pending-data hazard detection, operand select,
// and a registered valid/ready output slot with flush and a saturating stall counter.
module alu_operand_stage #(
  parameter int XLEN   = 32,
  parameter int NFWD   = 2,
  parameter int REG_AW = 5,
  parameter int SEL_W  = 3,
  parameter int CNT_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SEL_W-1:0]       alu_src_sel,
  input  logic                   use_rs1,
  input  logic                   use_rs2,
  input  logic [REG_AW-1:0]      rs1_idx,
  input  logic [REG_AW-1:0]      rs2_idx,
  input  logic [XLEN-1:0]        reg1_rdata,
  input  logic [XLEN-1:0]        reg2_rdata,
  input  logic [XLEN-1:0]        imm,
  input  logic [XLEN-1:0]        curr_pc,
  input  logic [NFWD-1:0]        fwd_valid,
  input  logic [NFWD*REG_AW-1:0] fwd_rd_idx,
  input  logic [NFWD*XLEN-1:0]   fwd_data,
  input  logic [NFWD-1:0]        fwd_data_rdy,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        alu_src1,
  output logic [XLEN-1:0]        alu_src2,
  output logic [XLEN-1:0]        rs2_fwd_data,
  output logic                   hazard_stall,
  output logic [CNT_W-1:0]       stall_cnt
);

  localparam logic [SEL_W-1:0] SEL_IMM      = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_FOUR_PC  = SEL_W'(2);
  localparam logic [SEL_W-1:0] SEL_IMM_PC   = SEL_W'(3);
  localparam logic [SEL_W-1:0] SEL_ZERO_IMM = SEL_W'(4);
  localparam logic [XLEN-1:0]  CONST_FOUR   = XLEN'(4);

  logic [XLEN-1:0]  rs1_val, rs2_val;
  logic             rs1_pend, rs2_pend;
  logic [XLEN-1:0]  src1_d, src2_d;
  logic             accept;
  logic             valid_d, valid_q;
  logic [XLEN-1:0]  src1_q, src2_q, rs2_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Scan oldest to youngest so the youngest matching source is the last one written.
  always_comb begin
    rs1_val  = reg1_rdata;
    rs1_pend = 1'b0;
    rs2_val  = reg2_rdata;
    rs2_pend = 1'b0;
    for (int k = NFWD - 1; k >= 0; k--) begin
      if (fwd_valid[k] && (fwd_rd_idx[k*REG_AW +: REG_AW] == rs1_idx) && (rs1_idx != '0)) begin
        rs1_val  = fwd_data[k*XLEN +: XLEN];
        rs1_pend = !fwd_data_rdy[k];
      end
      if (fwd_valid[k] && (fwd_rd_idx[k*REG_AW +: REG_AW] == rs2_idx) && (rs2_idx != '0)) begin
        rs2_val  = fwd_data[k*XLEN +: XLEN];
        rs2_pend = !fwd_data_rdy[k];
      end
    end
  end

  assign hazard_stall = in_valid && ((use_rs1 && rs1_pend) || (use_rs2 && rs2_pend));
  assign in_ready     = (!valid_q || out_ready) && !hazard_stall;
  assign accept       = in_valid && in_ready;

  always_comb begin
    src1_d = rs1_val;
    src2_d = rs2_val;
    case (alu_src_sel)
      SEL_IMM: begin
        src1_d = rs1_val;
        src2_d = imm;
      end
      SEL_FOUR_PC: begin
        src1_d = CONST_FOUR;
        src2_d = curr_pc;
      end
      SEL_IMM_PC: begin
        src1_d = imm;
        src2_d = curr_pc;
      end
      SEL_ZERO_IMM: begin
        src1_d = '0;
        src2_d = imm;
      end
      default: begin
        src1_d = rs1_val;
        src2_d = rs2_val;
      end
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    if (flush)
      valid_d = 1'b0;
    else if (accept)
      valid_d = 1'b1;
    else if (out_ready)
      valid_d = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (hazard_stall && !flush && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // Data may load under flush; valid is already forced low so the values are never observed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src1_q <= '0;
      src2_q <= '0;
      rs2_q  <= '0;
    end else if (accept) begin
      src1_q <= src1_d;
      src2_q <= src2_d;
      rs2_q  <= rs2_val;
    end
  end

  assign out_valid    = valid_q;
  assign alu_src1     = src1_q;
  assign alu_src2     = src2_q;
  assign rs2_fwd_data = rs2_q;
  assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed and random checks of alu_operand_stage against a behavioural model.
module tb_alu_operand_stage;
  localparam int XLEN   = 32;
  localparam int NFWD   = 2;
  localparam int REG_AW = 5;
  localparam int SEL_W  = 3;
  localparam int CNT_W  = 4;  // narrow counter so saturation is reachable
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid, in_ready;
  logic [SEL_W-1:0]       alu_src_sel;
  logic                   use_rs1, use_rs2;
  logic [REG_AW-1:0]      rs1_idx, rs2_idx;
  logic [XLEN-1:0]        reg1_rdata, reg2_rdata, imm, curr_pc;
  logic [NFWD-1:0]        fwd_valid, fwd_data_rdy;
  logic [NFWD*REG_AW-1:0] fwd_rd_idx;
  logic [NFWD*XLEN-1:0]   fwd_data;
  logic                   flush, out_valid, out_ready;
  logic [XLEN-1:0]        alu_src1, alu_src2, rs2_fwd_data;
  logic                   hazard_stall;
  logic [CNT_W-1:0]       stall_cnt;

  logic              f_valid [NFWD];
  logic [REG_AW-1:0] f_rd    [NFWD];
  logic [XLEN-1:0]   f_data  [NFWD];
  logic              f_rdy   [NFWD];

  alu_operand_stage #(
    .XLEN(XLEN), .NFWD(NFWD), .REG_AW(REG_AW), .SEL_W(SEL_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_src_sel(alu_src_sel), .use_rs1(use_rs1), .use_rs2(use_rs2),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .reg1_rdata(reg1_rdata), .reg2_rdata(reg2_rdata),
    .imm(imm), .curr_pc(curr_pc), .fwd_valid(fwd_valid), .fwd_rd_idx(fwd_rd_idx),
    .fwd_data(fwd_data), .fwd_data_rdy(fwd_data_rdy), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .rs2_fwd_data(rs2_fwd_data), .hazard_stall(hazard_stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  always_comb begin
    fwd_valid    = '0;
    fwd_data_rdy = '0;
    fwd_rd_idx   = '0;
    fwd_data     = '0;
    for (int k = 0; k < NFWD; k++) begin
      fwd_valid[k]                    = f_valid[k];
      fwd_data_rdy[k]                 = f_rdy[k];
      fwd_rd_idx[k*REG_AW +: REG_AW]  = f_rd[k];
      fwd_data[k*XLEN +: XLEN]        = f_data[k];
    end
  end

  int vectors = 0;
  int miscompares = 0;

  // Model state
  logic            m_valid;
  logic [XLEN-1:0] m_src1, m_src2, m_rs2;
  int              m_stalls;
  logic            e_hz, e_rdy;
  logic [XLEN-1:0] e_s1, e_s2, e_r2;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // First matching source in priority order wins; x0 never matches.
  task automatic lookup(input logic [REG_AW-1:0] idx, input logic [XLEN-1:0] rdat,
                        output logic [XLEN-1:0] val, output logic pend);
    val  = rdat;
    pend = 1'b0;
    if (idx != 0) begin
      for (int k = 0; k < NFWD; k++) begin
        if (f_valid[k] && f_rd[k] == idx) begin
          val  = f_data[k];
          pend = !f_rdy[k];
          break;
        end
      end
    end
  endtask

  task automatic model_comb();
    logic [XLEN-1:0] v1, v2;
    logic p1, p2;
    lookup(rs1_idx, reg1_rdata, v1, p1);
    lookup(rs2_idx, reg2_rdata, v2, p2);
    e_hz  = in_valid && ((use_rs1 && p1) || (use_rs2 && p2));
    e_rdy = (!m_valid || out_ready) && !e_hz;
    e_r2  = v2;
    case (int'(alu_src_sel))
      1:       begin e_s1 = v1;      e_s2 = imm;     end
      2:       begin e_s1 = 32'd4;   e_s2 = curr_pc; end
      3:       begin e_s1 = imm;     e_s2 = curr_pc; end
      4:       begin e_s1 = 32'd0;   e_s2 = imm;     end
      default: begin e_s1 = v1;      e_s2 = v2;      end
    endcase
  endtask

  task automatic model_reset();
    m_valid  = 1'b0;
    m_src1   = '0;
    m_src2   = '0;
    m_rs2    = '0;
    m_stalls = 0;
  endtask

  // Inputs are already driven; check combinational outputs, clock once, check registers.
  task automatic cycle();
    logic acc, fl, ordy, hz;
    #1;
    model_comb();
    chk("hazard_stall", XLEN'(hazard_stall), XLEN'(e_hz));
    chk("in_ready", XLEN'(in_ready), XLEN'(e_rdy));
    acc  = in_valid && e_rdy;
    fl   = flush;
    ordy = out_ready;
    hz   = e_hz;
    @(posedge clk);
    if (hz && !fl) m_stalls++;
    if (fl)
      m_valid = 1'b0;
    else if (acc) begin
      m_valid = 1'b1;
      m_src1  = e_s1;
      m_src2  = e_s2;
      m_rs2   = e_r2;
    end else if (m_valid && ordy)
      m_valid = 1'b0;
    #1;
    chk("out_valid", XLEN'(out_valid), XLEN'(m_valid));
    chk("stall_cnt", XLEN'(stall_cnt), (m_stalls > CNT_MAX) ? CNT_MAX : m_stalls);
    if (m_valid) begin
      chk("alu_src1", alu_src1, m_src1);
      chk("alu_src2", alu_src2, m_src2);
      chk("rs2_fwd_data", rs2_fwd_data, m_rs2);
    end
  endtask

  task automatic idle_inputs();
    in_valid = 0; alu_src_sel = '0; use_rs1 = 0; use_rs2 = 0;
    rs1_idx = '0; rs2_idx = '0; reg1_rdata = '0; reg2_rdata = '0;
    imm = '0; curr_pc = '0; flush = 0; out_ready = 1;
    for (int k = 0; k < NFWD; k++) begin
      f_valid[k] = 0; f_rd[k] = '0; f_data[k] = '0; f_rdy[k] = 1;
    end
  endtask

  logic [XLEN-1:0] hold1, hold2;

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    #2;
    chk("rst_out_valid", XLEN'(out_valid), 0);
    chk("rst_src1", alu_src1, 0);
    chk("rst_src2", alu_src2, 0);
    chk("rst_rs2", rs2_fwd_data, 0);
    chk("rst_stall_cnt", XLEN'(stall_cnt), 0);
    #4 rst = 1'b0;
    @(posedge clk); #1;

    // Youngest forwarding source wins
    in_valid = 1; alu_src_sel = 3'd0; use_rs1 = 1; use_rs2 = 1; rs1_idx = 5; rs2_idx = 6;
    reg1_rdata = 32'hAAAA; reg2_rdata = 32'hBBBB;
    f_valid[0] = 1; f_rd[0] = 5; f_data[0] = 32'h11; f_rdy[0] = 1;
    f_valid[1] = 1; f_rd[1] = 5; f_data[1] = 32'h22; f_rdy[1] = 1;
    cycle();
    chk("youngest_wins", alu_src1, 32'h11);
    chk("rs2_from_reg", rs2_fwd_data, 32'hBBBB);

    // x0 never forwards
    rs1_idx = 0; reg1_rdata = 0; f_rd[0] = 0; f_data[0] = 32'hFF; f_valid[1] = 0;
    cycle();
    chk("x0_regfile", alu_src1, 32'h0);

    // Pending younger load on rs1 stalls the IMM op for two cycles
    alu_src_sel = 3'd1; rs1_idx = 3; use_rs2 = 0; imm = 32'h7;
    f_valid[0] = 1; f_rd[0] = 3; f_data[0] = 32'h33; f_rdy[0] = 0;
    f_valid[1] = 1; f_rd[1] = 3; f_data[1] = 32'h44; f_rdy[1] = 1;
    cycle();
    cycle();
    f_rdy[0] = 1;
    cycle();
    chk("stall_two", XLEN'(stall_cnt), 2);
    chk("stall_fwd", alu_src1, 32'h33);

    // FOUR_PC and ZERO_IMM
    alu_src_sel = 3'd2; curr_pc = 32'h100;
    cycle();
    chk("four_pc_s1", alu_src1, 32'd4);
    chk("four_pc_s2", alu_src2, 32'h100);
    alu_src_sel = 3'd4; imm = 32'h12345000;
    cycle();
    chk("zero_imm_s1", alu_src1, 32'd0);
    chk("zero_imm_s2", alu_src2, 32'h12345000);

    // Backpressure: outputs hold while EX is not ready
    alu_src_sel = 3'd3; imm = 32'h55; curr_pc = 32'h200; out_ready = 0;
    hold1 = alu_src1; hold2 = alu_src2;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_hold_s1", alu_src1, hold1);
      chk("bp_hold_s2", alu_src2, hold2);
    end
    out_ready = 1;
    cycle();
    chk("bp_release_s1", alu_src1, 32'h55);
    chk("bp_release_s2", alu_src2, 32'h200);

    // Flush in the accept cycle kills the op
    flush = 1;
    cycle();
    chk("flush_kill", XLEN'(out_valid), 0);
    flush = 0; in_valid = 0;
    cycle();

    // Counter saturates
    in_valid = 1; alu_src_sel = 3'd0; rs1_idx = 9; f_rd[0] = 9; f_rdy[0] = 0;
    for (int i = 0; i < 20; i++) cycle();
    chk("stall_saturate", XLEN'(stall_cnt), CNT_MAX);

    // Async reset mid-stream
    f_rdy[0] = 1;
    cycle();
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst_valid", XLEN'(out_valid), 0);
    chk("async_rst_cnt", XLEN'(stall_cnt), 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      in_valid    = 1'($urandom_range(0, 3) != 0);
      alu_src_sel = SEL_W'($urandom_range(0, 7));
      use_rs1     = 1'($urandom_range(0, 1));
      use_rs2     = 1'($urandom_range(0, 1));
      rs1_idx     = REG_AW'($urandom_range(0, 5));
      rs2_idx     = REG_AW'($urandom_range(0, 5));
      reg1_rdata  = $urandom;
      reg2_rdata  = $urandom;
      imm         = $urandom;
      curr_pc     = $urandom;
      out_ready   = 1'($urandom_range(0, 3) != 0);
      flush       = 1'($urandom_range(0, 15) == 0);
      for (int k = 0; k < NFWD; k++) begin
        f_valid[k] = 1'($urandom_range(0, 1));
        f_rd[k]    = REG_AW'($urandom_range(0, 5));
        f_data[k]  = $urandom;
        f_rdy[k]   = 1'($urandom_range(0, 3) != 0);
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
